bcd_display_rx: RTL and testbench
=================================

Name: bcd_display_rx

Overview:
Receiving end of the serial BCD display link driven by the calculator's display output stage. Deserialises 16-bit BCD frames from the data-enable/data pair, one bit per serial-clock tick, and latches each complete frame. It drives a 4-digit multiplexed common-anode 7-segment display from the latched value. It also flags short (aborted) frames so the bench and any status logic can detect link errors.

Parameters:
REFRESH_COUNT, 12000, clk cycles each digit stays lit (48 MHz HFOSC -> 4 kHz digit rate); legal range 2 to 2^20.
BLANK_LEADING, 1, 1 = blank leading zero digits 3..1; 0 = always show all four digits.

Ports:
clk  input  1  system clock (HFOSC domain)
rst  input  1  synchronous, active-high reset
ser_tick  input  1  one-clk-cycle strobe, rising edge of serial clock; bit-sample qualifier
data_en  input  1  frame envelope; high for the whole 16-bit frame
data  input  1  serial BCD bit, MSB (digit 3 bit 3) first
bcd_value  output  16  last complete frame; [15:12]=digit 3 ... [3:0]=digit 0
frame_valid  output  1  one-cycle pulse, new frame latched
frame_error  output  1  one-cycle pulse, frame aborted before 16 bits
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
an  output  4  digit anodes, one-hot active-low; an[0] = rightmost digit

Behaviour:
- Clock and reset: single clk; reset is synchronous and active-high.
- All outputs are registered. Reset values: bcd_value=0, frame_valid=0, frame_error=0, an=4'b1110, seg=7'b1000000 ("0"). Reset also clears the shift register, bit counter, FSM (-> IDLE), refresh counter and digit index.
- rst asserted mid-frame discards the partial frame, with no error pulse.
- FSM states: IDLE, RECV, HOLD.
- IDLE:
  - data_en=1 -> RECV with bit count cleared.
  - If ser_tick=1 in the same cycle, that bit is sampled as bit 15 and the count becomes 1.
- RECV:
  - Each cycle with ser_tick=1 and data_en=1: shift = {shift[14:0], data}, count+1.
  - On the edge sampling the 16th bit: bcd_value <= {shift[14:0], data}, frame_valid=1 for the next cycle only, -> HOLD.
  - data_en=0 with count<16: frame_error=1 for one cycle, bcd_value unchanged, -> IDLE.
  - ser_tick with data_en=0 is ignored in every state.
- HOLD:
  - All ticks are ignored (extra bits are dropped, not an error).
  - data_en=0 -> IDLE.
  - A new frame requires data_en to be low for at least one clk cycle.
- frame_valid and frame_error are never asserted in the same cycle.
- Display multiplexing:
  - Refresh counter runs 0..REFRESH_COUNT-1 continuously, independent of the FSM.
  - On wrap, digit index advances 0->1->2->3->0.
  - an and seg update together on the same edge, so there is no ghosting cycle.
- Decode: nibbles 0-9 use the standard patterns, active-low (e.g. 1 = 7'b1111001, 8 = 7'b0000000). Nibble >9 shows "-" (7'b0111111).
- Blanking (BLANK_LEADING=1):
  - Digit k (k=3..1) is blanked (seg=7'b1111111, its an still asserted) when it and all higher digits are zero.
  - Digit 0 is never blanked.
  - A nibble >9 counts as non-zero.
- A new bcd_value takes effect at the next digit slot; the current slot is not restarted.

Test Plan:
- Reset then idle 4*REFRESH_COUNT cycles -> an cycles 1110,1101,1011,0111; seg=1000000 on digit 0, 1111111 on digits 1-3.
- Send frame 16'h1234 (ticks every 8 clk, data_en high throughout) -> frame_valid pulses once, one cycle after the 16th tick; bcd_value=16'h1234; digits show 4,3,2,1 (seg 0011001, 0110000, 0100100, 1111001).
- Send 16'h0057 -> digits 3,2 blank; digit 1=5 (0010010); digit 0=7 (1111000). With BLANK_LEADING=0, digits 3,2 show 1000000.
- Drop data_en after 9 ticks -> frame_error one-cycle pulse, no frame_valid, bcd_value stays 16'h0057. A following full frame 16'h9999 latches correctly.
- Hold data_en for 20 ticks with frame 16'hA0F1 -> frame_valid once after tick 16, ticks 17-20 ignored; digits show 1,-,0,- (0 not blanked because a higher digit is non-zero).
- Assert rst at tick 10 of a frame -> no pulses; outputs return to reset values; next frame received normally.

Source files
------------

// File: rtl/bcd_display_rx_if.sv
// Signal bundle between the calculator's serial BCD display link and the
// display receiver: serial link inputs plus latched value, status pulses and display drive.
interface bcd_display_rx_if;
    logic        ser_tick;
    logic        data_en;
    logic        data;
    logic [15:0] bcd_value;
    logic        frame_valid;
    logic        frame_error;
    logic [6:0]  seg;
    logic [3:0]  an;

    modport master (
        output ser_tick,
        output data_en,
        output data,
        input  bcd_value,
        input  frame_valid,
        input  frame_error,
        input  seg,
        input  an
    );

    modport slave (
        input  ser_tick,
        input  data_en,
        input  data,
        output bcd_value,
        output frame_valid,
        output frame_error,
        output seg,
        output an
    );
endinterface

// File: rtl/bcd_display_rx.sv
// Serial BCD display link receiver: deserialises 16-bit frames, flags aborted
// frames and drives a 4-digit multiplexed common-anode 7-segment display.
module bcd_display_rx #(
    parameter int REFRESH_COUNT = 12000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input logic             clk,
    input logic             rst,
    bcd_display_rx_if.slave bus
);

    localparam int CW = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;
    localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [14:0] shift_q, shift_d;
    logic [4:0]  count_q, count_d;
    logic [15:0] bcd_q, bcd_d;
    logic        valid_q, valid_d;
    logic        error_q, error_d;

    logic [CW-1:0] refresh_q, refresh_d;
    logic [1:0]    digit_q, digit_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    nibble;
    logic          blank;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] pattern;
        case (n)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = 7'b0111111;
        endcase
        return pattern;
    endfunction

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        bcd_d   = bcd_q;
        valid_d = 1'b0;
        error_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.data_en) begin
                    state_d = RECV;
                    count_d = 5'd0;
                    if (bus.ser_tick) begin
                        shift_d = {shift_q[13:0], bus.data};
                        count_d = 5'd1;
                    end
                end
            end
            RECV: begin
                // Envelope dropping before the 16th bit is an aborted frame.
                if (!bus.data_en) begin
                    error_d = 1'b1;
                    count_d = 5'd0;
                    state_d = IDLE;
                end else if (bus.ser_tick) begin
                    shift_d = {shift_q[13:0], bus.data};
                    count_d = count_q + 5'd1;
                    if (count_q == 5'd15) begin
                        bcd_d   = {shift_q, bus.data};
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!bus.data_en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            count_q <= '0;
            bcd_q   <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    // Anode and segments are loaded together at slot start from the digit about
    // to be lit, so a new value only appears at the next slot and never ghosts.
    always_comb begin
        refresh_d = refresh_q + 1'b1;
        digit_d   = digit_q;
        an_d      = an_q;
        seg_d     = seg_q;
        nibble    = 4'd0;
        blank     = 1'b0;
        if (refresh_q == REFRESH_LAST) begin
            refresh_d = '0;
            digit_d   = digit_q + 2'd1;
            case (digit_d)
                2'd0: begin
                    nibble = bcd_q[3:0];
                    blank  = 1'b0;
                end
                2'd1: begin
                    nibble = bcd_q[7:4];
                    blank  = (bcd_q[15:4] == 12'd0);
                end
                2'd2: begin
                    nibble = bcd_q[11:8];
                    blank  = (bcd_q[15:8] == 8'd0);
                end
                default: begin
                    nibble = bcd_q[15:12];
                    blank  = (bcd_q[15:12] == 4'd0);
                end
            endcase
            an_d  = ~(4'b0001 << digit_d);
            seg_d = (blank && BLANK_LEADING) ? 7'b1111111 : decode(nibble);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_q <= '0;
            digit_q   <= 2'd0;
            an_q      <= 4'b1110;
            seg_q     <= 7'b1000000;
        end else begin
            refresh_q <= refresh_d;
            digit_q   <= digit_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign bus.bcd_value   = bcd_q;
    assign bus.frame_valid = valid_q;
    assign bus.frame_error = error_q;
    assign bus.seg         = seg_q;
    assign bus.an          = an_q;

endmodule

// File: tb/tb_bcd_display_rx.sv
// Bench for bcd_display_rx: table-driven frames, randomized frames against a
// frame/display model, and hand sequences for idle ticks and mid-frame reset.
module tb_bcd_display_rx;

    localparam int R = 16;

    typedef struct {
        logic [15:0] value;
        int          nTicks;
        bit          sameCycle;
        bit          expValid;
        bit          expError;
        logic [15:0] expBcd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    bcd_display_rx_if busA();
    bcd_display_rx_if busB();

    assign busB.ser_tick = busA.ser_tick;
    assign busB.data_en  = busA.data_en;
    assign busB.data     = busA.data;

    bcd_display_rx #(.REFRESH_COUNT(R), .BLANK_LEADING(1'b1)) dutA (
        .clk(clk),
        .rst(rst),
        .bus(busA)
    );

    bcd_display_rx #(.REFRESH_COUNT(R), .BLANK_LEADING(1'b0)) dutB (
        .clk(clk),
        .rst(rst),
        .bus(busB)
    );

    int          checks = 0;
    int          failures = 0;
    int          k = 0;
    int          validCnt = 0;
    int          errorCnt = 0;
    logic [15:0] expBcd = 16'h0000;
    vec_t        vecs[8];

    // Cycles since reset release; the lit digit is simply (k / R) mod 4.
    always @(posedge clk) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    always @(negedge clk) begin
        if (busA.frame_valid) validCnt++;
        if (busA.frame_error) errorCnt++;
    end

    function automatic logic [6:0] expSeg(input logic [15:0] v, input int d, input bit blankLead);
        logic [15:0] upper;
        logic [3:0]  n;
        upper = v >> (4 * d);
        n     = upper[3:0];
        if (blankLead && d > 0 && upper == 16'd0) return 7'b1111111;
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic checkDisplay(input string label);
        logic [3:0] expAn;
        int         d;
        repeat (4 * R) begin
            @(negedge clk);
            if (k % R == R / 2) begin
                d     = (k / R) % 4;
                expAn = ~(4'b0001 << d);
                checkOutput({label, "-anA"}, busA.an, expAn);
                checkOutput({label, "-segA"}, busA.seg, expSeg(expBcd, d, 1'b1));
                checkOutput({label, "-anB"}, busB.an, expAn);
                checkOutput({label, "-segB"}, busB.seg, expSeg(expBcd, d, 1'b0));
            end
        end
    endtask

    task automatic applyStimulus(input logic [15:0] value, input int nTicks, input int period,
                                 input bit sameCycle, input bit expValid, input bit expError,
                                 input logic [15:0] expBcdNew);
        int validBefore;
        int errorBefore;
        int w;
        validBefore = validCnt;
        errorBefore = errorCnt;
        @(negedge clk);
        busA.data_en = 1'b1;
        for (int i = 0; i < nTicks; i++) begin
            w = (i == 0 && sameCycle) ? 0 : period - 1;
            repeat (w) @(negedge clk);
            busA.data     = (i < 16) ? value[15 - i] : 1'($urandom);
            busA.ser_tick = 1'b1;
            @(negedge clk);
            busA.ser_tick = 1'b0;
            busA.data     = 1'b0;
            if (i == 15) begin
                checkOutput("valid-latency", busA.frame_valid, 1'b1);
                checkOutput("bcd-latched", busA.bcd_value, value);
            end
        end
        repeat (2) @(negedge clk);
        busA.data_en = 1'b0;
        @(negedge clk);
        checkOutput("error-pulse", busA.frame_error, expError);
        expBcd = expBcdNew;
        repeat (R + 2) @(negedge clk);
        checkOutput("valid-count", validCnt - validBefore, expValid ? 1 : 0);
        checkOutput("error-count", errorCnt - errorBefore, expError ? 1 : 0);
        checkOutput("bcd-value", busA.bcd_value, expBcd);
        checkOutput("bcd-value-B", busB.bcd_value, expBcd);
    endtask

    initial begin
        logic [15:0] rv;
        int          nt;
        int          sel;
        int          vb;
        int          eb;
        bit          ev;

        busA.ser_tick = 1'b0;
        busA.data_en  = 1'b0;
        busA.data     = 1'b0;

        vecs[0] = '{16'h1234, 16, 1'b0, 1'b1, 1'b0, 16'h1234};
        vecs[1] = '{16'h0057, 16, 1'b1, 1'b1, 1'b0, 16'h0057};
        vecs[2] = '{16'h8642,  9, 1'b0, 1'b0, 1'b1, 16'h0057};
        vecs[3] = '{16'h9999, 16, 1'b0, 1'b1, 1'b0, 16'h9999};
        vecs[4] = '{16'hA0F1, 20, 1'b0, 1'b1, 1'b0, 16'hA0F1};
        vecs[5] = '{16'h0000, 16, 1'b1, 1'b1, 1'b0, 16'h0000};
        vecs[6] = '{16'h0800, 16, 1'b0, 1'b1, 1'b0, 16'h0800};
        vecs[7] = '{16'h5555,  0, 1'b0, 1'b0, 1'b1, 16'h0800};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset-bcd", busA.bcd_value, 16'h0000);
        checkOutput("reset-valid", busA.frame_valid, 1'b0);
        checkOutput("reset-error", busA.frame_error, 1'b0);
        checkOutput("reset-an", busA.an, 4'b1110);
        checkOutput("reset-seg", busA.seg, 7'b1000000);
        checkDisplay("idle");

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].value, vecs[i].nTicks, 8, vecs[i].sameCycle,
                          vecs[i].expValid, vecs[i].expError, vecs[i].expBcd);
            checkDisplay($sformatf("vec%0d", i));
        end

        // Ticks without the envelope must be ignored entirely.
        vb = validCnt;
        eb = errorCnt;
        repeat (20) begin
            @(negedge clk);
            busA.data     = 1'($urandom);
            busA.ser_tick = 1'b1;
            @(negedge clk);
            busA.ser_tick = 1'b0;
        end
        repeat (4) @(negedge clk);
        checkOutput("idle-ticks-valid", validCnt - vb, 0);
        checkOutput("idle-ticks-error", errorCnt - eb, 0);
        checkOutput("idle-ticks-bcd", busA.bcd_value, expBcd);

        for (int it = 0; it < 25; it++) begin
            rv  = 16'($urandom);
            sel = $urandom_range(0, 9);
            if (sel < 6)      nt = 16;
            else if (sel < 8) nt = $urandom_range(0, 15);
            else              nt = $urandom_range(17, 20);
            ev = (nt >= 16);
            applyStimulus(rv, nt, $urandom_range(2, 8), 1'($urandom_range(0, 1)),
                          ev, !ev, ev ? rv : expBcd);
            if (it % 5 == 0) checkDisplay($sformatf("rand%0d", it));
        end

        // Reset in the middle of a frame discards it silently.
        @(negedge clk);
        busA.data_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            repeat (3) @(negedge clk);
            busA.data     = 1'($urandom);
            busA.ser_tick = 1'b1;
            @(negedge clk);
            busA.ser_tick = 1'b0;
        end
        vb = validCnt;
        eb = errorCnt;
        rst          = 1'b1;
        busA.data_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expBcd = 16'h0000;
        checkOutput("midreset-bcd", busA.bcd_value, 16'h0000);
        checkOutput("midreset-an", busA.an, 4'b1110);
        checkOutput("midreset-seg", busA.seg, 7'b1000000);
        repeat (R) @(negedge clk);
        checkOutput("midreset-valid", validCnt - vb, 0);
        checkOutput("midreset-error", errorCnt - eb, 0);
        checkDisplay("midreset");
        applyStimulus(16'h4321, 16, 5, 1'b0, 1'b1, 1'b0, 16'h4321);
        checkDisplay("post-reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
